// File: rtl/mul_pkg.sv
// Shared multiplier datapath constants and Booth digit encoding.
// Used by the partial-product generator and the downstream compressor tree.
package mul_pkg;

    localparam int OP_W   = 32;
    localparam int PP_W   = 64;
    localparam int PP_NUM = 16;

    typedef enum logic [2:0] {
        BD_ZERO,
        BD_P1,
        BD_P2,
        BD_M1,
        BD_M2
    } booth_dig_t;

    // Window is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_dig_t booth_decode(input logic [2:0] win);
        booth_dig_t d;
        case (win)
            3'b001, 3'b010: d = BD_P1;
            3'b011:         d = BD_P2;
            3'b100:         d = BD_M2;
            3'b101, 3'b110: d = BD_M1;
            default:        d = BD_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_gen_if.sv
// Operand / partial-product handshake bundle for booth_pp_gen.
// slave = the generator, master = the operand source and row consumer.
interface booth_pp_gen_if
    import mul_pkg::*;
#(
    parameter int TAG_W = 4
) ();

    logic                          in_valid;
    logic                          in_ready;
    logic [OP_W-1:0]               in_a;
    logic [OP_W-1:0]               in_b;
    logic [TAG_W-1:0]              in_tag;
    logic                          out_valid;
    logic                          out_ready;
    logic [PP_NUM-1:0][PP_W-1:0]   out_pp;
    logic [TAG_W-1:0]              out_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_pp, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_pp, out_tag
    );

endinterface

// File: rtl/booth_row_sel.sv
// One radix-4 Booth row: selects 0/+-A/+-2A from a 3-bit digit window.
// Output is unshifted and exactly negated; the caller applies the 2i shift.
module booth_row_sel
    import mul_pkg::*;
(
    input  logic [2:0]      i_win,
    input  logic [PP_W-1:0] i_a_sext,
    output logic [PP_W-1:0] o_row
);

    booth_dig_t      w_dig;
    logic [PP_W-1:0] w_mag;
    logic            w_neg;

    assign w_dig = booth_decode(i_win);

    always_comb begin
        w_mag = '0;
        w_neg = 1'b0;
        case (w_dig)
            BD_P1: w_mag = i_a_sext;
            BD_P2: w_mag = i_a_sext << 1;
            BD_M1: begin
                w_mag = i_a_sext;
                w_neg = 1'b1;
            end
            BD_M2: begin
                w_mag = i_a_sext << 1;
                w_neg = 1'b1;
            end
            default: w_mag = '0;
        endcase
    end

    assign o_row = w_neg ? (~w_mag + PP_W'(1)) : w_mag;

endmodule

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator: 16 registered, pre-shifted 64-bit rows per op.
// Define BOOTH_PP_SKID_EN for a 1-entry skid so in_ready has no path from out_ready.
module booth_pp_gen
    import mul_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    booth_pp_gen_if.slave bus
);

    logic                        w_in_xfer;
    logic                        w_out_free;
    logic                        w_load;
    logic [OP_W-1:0]             w_src_a;
    logic [OP_W-1:0]             w_src_b;
    logic [TAG_W-1:0]            w_src_tag;
    logic [PP_W-1:0]             w_a_sext;
    logic [OP_W:0]               w_b_ext;
    logic [PP_NUM-1:0][PP_W-1:0] w_row_raw;
    logic [PP_NUM-1:0][PP_W-1:0] w_rows;

    logic                        r_out_valid;
    logic [PP_NUM-1:0][PP_W-1:0] r_pp;
    logic [TAG_W-1:0]            r_tag;

    assign w_out_free = ~r_out_valid | bus.out_ready;
    assign w_in_xfer  = bus.in_valid & bus.in_ready;

`ifdef BOOTH_PP_SKID_EN
    // Skid stores raw operands; rows are regenerated when it drains.
    logic             r_skid_valid;
    logic [OP_W-1:0]  r_skid_a;
    logic [OP_W-1:0]  r_skid_b;
    logic [TAG_W-1:0] r_skid_tag;

    assign bus.in_ready = ~r_skid_valid;
    assign w_src_a      = r_skid_valid ? r_skid_a   : bus.in_a;
    assign w_src_b      = r_skid_valid ? r_skid_b   : bus.in_b;
    assign w_src_tag    = r_skid_valid ? r_skid_tag : bus.in_tag;
    assign w_load       = w_out_free & (r_skid_valid | w_in_xfer);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_valid <= 1'b0;
            r_skid_a     <= '0;
            r_skid_b     <= '0;
            r_skid_tag   <= '0;
        end else if (w_in_xfer && !w_out_free) begin
            r_skid_valid <= 1'b1;
            r_skid_a     <= bus.in_a;
            r_skid_b     <= bus.in_b;
            r_skid_tag   <= bus.in_tag;
        end else if (r_skid_valid && w_out_free) begin
            r_skid_valid <= 1'b0;
        end
    end
`else
    assign bus.in_ready = w_out_free;
    assign w_src_a      = bus.in_a;
    assign w_src_b      = bus.in_b;
    assign w_src_tag    = bus.in_tag;
    assign w_load       = w_in_xfer;
`endif

    assign w_a_sext = {{(PP_W-OP_W){w_src_a[OP_W-1]}}, w_src_a};
    assign w_b_ext  = {w_src_b, 1'b0};

    generate
        for (genvar gi = 0; gi < PP_NUM; gi++) begin : g_row
            booth_row_sel u_row (
                .i_win    (w_b_ext[2*gi+2 -: 3]),
                .i_a_sext (w_a_sext),
                .o_row    (w_row_raw[gi])
            );
            assign w_rows[gi] = w_row_raw[gi] << (2*gi);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_pp        <= '0;
            r_tag       <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_pp        <= w_rows;
            r_tag       <= w_src_tag;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_pp    = r_pp;
    assign bus.out_tag   = r_tag;

endmodule
